dht11_sampler: RTL and testbench

Sits directly upstream and downstream of the DHT11 controller. It issues the controller's one-cycle start pulse, either periodically or on a manual request, and enforces the sensor's minimum inter-read gap. It times out stuck transactions and captures the integer bytes of humidity and temperature. It converts those bytes to 3-digit BCD with a sequential double-dabble for the FND display path.

---
 rtl/dht11_sampler_if.sv | 27 ++
 rtl/dht11_sampler.sv | 169 ++++++++++++++++
 tb/tb_dht11_sampler.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_sampler_if.sv
// Signal bundle between the DHT11 sampler, the sensor controller, the
// request/mode inputs and the FND display path.
interface dht11_sampler_if;
  logic        req;
  logic        auto_en;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        dht11_done;
  logic        dht11_valid;
  logic        dht11_start;
  logic [11:0] hum_bcd;
  logic [11:0] tmp_bcd;
  logic        data_ready;
  logic        stale;
  logic [7:0]  err_cnt;
  logic        busy;

  modport master (
    input  req, auto_en, humidity, temperature, dht11_done, dht11_valid,
    output dht11_start, hum_bcd, tmp_bcd, data_ready, stale, err_cnt, busy
  );

  modport slave (
    output req, auto_en, humidity, temperature, dht11_done, dht11_valid,
    input  dht11_start, hum_bcd, tmp_bcd, data_ready, stale, err_cnt, busy
  );
endinterface

// File: rtl/dht11_sampler.sv
// Triggers DHT11 reads (periodic or on request) with a minimum gap, times out
// stuck reads, and converts the integer bytes to 3-digit BCD by double-dabble.
module dht11_sampler #(
  parameter int TICK_DIV   = 100_000,
  parameter int MIN_GAP_MS = 1000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 50
) (
  input logic             clk,
  input logic             rst,
  dht11_sampler_if.master bus
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = $clog2(PERIOD_MS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_MS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_MIN  = GAP_W'(MIN_GAP_MS);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(PERIOD_MS);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_DONE = 3'd2,
    CONVERT   = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [GAP_W-1:0]  gap_ms;
  logic [WAIT_W-1:0] wait_ms;
  logic              pending;
  logic [2:0]        iter;

  logic              enter_trig;
  logic              capture;
  logic              fail;

  logic [7:0]        hum_sh, tmp_sh;
  logic [11:0]       hum_acc, tmp_acc;

  logic              start_r;
  logic [11:0]       hum_bcd_r, tmp_bcd_r;
  logic              ready_r;
  logic              stale_r;
  logic [7:0]        err_r;

  logic              unused_frac;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [11:0] bcd, input logic [7:0] sh);
    logic [11:0] adj;
    adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
    return {adj, sh} << 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tick        = (div_cnt == DIV_LAST);
  assign unused_frac = ^{bus.humidity[7:0], bus.temperature[7:0]};

  always_comb begin
    state_next = state;
    enter_trig = 1'b0;
    capture    = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        if (gap_ms >= GAP_MIN && (pending || (bus.auto_en && gap_ms == GAP_MAX))) begin
          state_next = TRIG;
          enter_trig = 1'b1;
        end
      end
      TRIG: state_next = WAIT_DONE;
      WAIT_DONE: begin
        // A done arriving in the timeout cycle still counts as a response.
        if (bus.dht11_done) begin
          if (bus.dht11_valid) begin
            state_next = CONVERT;
            capture    = 1'b1;
          end else begin
            state_next = IDLE;
            fail       = 1'b1;
          end
        end else if (wait_ms == WAIT_MAX) begin
          state_next = IDLE;
          fail       = 1'b1;
        end
      end
      CONVERT: if (iter == 3'd7) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_ms    <= '0;
      wait_ms   <= '0;
      pending   <= 1'b0;
      iter      <= '0;
      start_r   <= 1'b0;
      hum_bcd_r <= '0;
      tmp_bcd_r <= '0;
      ready_r   <= 1'b0;
      stale_r   <= 1'b0;
      err_r     <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

      if (enter_trig)                  gap_ms <= '0;
      else if (tick && gap_ms != GAP_MAX) gap_ms <= gap_ms + GAP_W'(1);

      if (state == TRIG)                   wait_ms <= '0;
      else if (state == WAIT_DONE && tick) wait_ms <= wait_ms + WAIT_W'(1);

      // A request landing on the trigger edge is served by this very trigger.
      pending <= enter_trig ? 1'b0 : (pending | bus.req);
      iter    <= (state == CONVERT) ? iter + 3'd1 : 3'd0;
      start_r <= enter_trig;
      ready_r <= (state == UPDATE);

      if (state == UPDATE) begin
        hum_bcd_r <= hum_acc;
        tmp_bcd_r <= tmp_acc;
        stale_r   <= 1'b0;
      end
      if (fail) begin
        stale_r <= 1'b1;
        err_r   <= sat_inc8(err_r);
      end
    end
  end

  // Conversion datapath; only consumed after a capture has initialised it.
  always_ff @(posedge clk) begin
    if (capture) begin
      hum_sh  <= bus.humidity[15:8];
      tmp_sh  <= bus.temperature[15:8];
      hum_acc <= '0;
      tmp_acc <= '0;
    end else if (state == CONVERT) begin
      {hum_acc, hum_sh} <= dd_step(hum_acc, hum_sh);
      {tmp_acc, tmp_sh} <= dd_step(tmp_acc, tmp_sh);
    end
  end

  assign bus.dht11_start = start_r;
  assign bus.hum_bcd     = hum_bcd_r;
  assign bus.tmp_bcd     = tmp_bcd_r;
  assign bus.data_ready  = ready_r;
  assign bus.stale       = stale_r;
  assign bus.err_cnt     = err_r;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_dht11_sampler.sv
// Randomized bench for dht11_sampler; expected timing comes from ms-tick arithmetic
// and expected BCD from integer division.
module tb_dht11_sampler;

  localparam int TD   = 10;
  localparam int MING = 5;
  localparam int PER  = 8;
  localparam int TMO  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dht11_sampler_if bus();

  dht11_sampler #(
    .TICK_DIV  (TD),
    .MIN_GAP_MS(MING),
    .PERIOD_MS (PER),
    .TIMEOUT_MS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc;
  int ready_cnt = 0;
  int pass_cnt  = 0;
  int total_cnt = 0;
  int last_trig = 0;

  // cyc = number of rising edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) if (bus.data_ready === 1'b1) ready_cnt <= ready_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Edge index of the n-th ms tick strictly after edge l (ticks land on multiples of TD).
  function automatic int tick_after(input int l, input int n);
    return (l / TD + n) * TD;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic pulse_req();
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic send_done(input logic v, input logic [15:0] h, input logic [15:0] t);
    bus.humidity    = h;
    bus.temperature = t;
    bus.dht11_valid = v;
    bus.dht11_done  = 1'b1;
    @(negedge clk);
    bus.dht11_done  = 1'b0;
    bus.dht11_valid = 1'b0;
  endtask

  task automatic wait_start(output int at, input int budget);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.dht11_start === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int at, input int budget);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.data_ready === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    outs = {bus.dht11_start, bus.hum_bcd, bus.tmp_bcd, bus.data_ready, bus.stale, bus.err_cnt, bus.busy};
    total_cnt++;
    if (outs !== 38'd0) $display("FAIL reset_outputs: got %h want 0", outs); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_auto_period();
    int s, r, k, exp_s;
    logic [15:0] h, t;
    bus.auto_en = 1'b1;
    last_trig = 0;
    for (int n = 0; n < 5; n++) begin
      exp_s = tick_after(last_trig, PER) + 1;
      wait_start(s, 200);
      total_cnt++;
      if (s !== exp_s) $display("FAIL auto_start%0d: got %0d want %0d", n, s, exp_s); else pass_cnt++;
      last_trig = (s < 0) ? exp_s : s;
      @(negedge clk);
      total_cnt++;
      if (bus.dht11_start !== 1'b0) $display("FAIL start_width%0d: got %b want 0", n, bus.dht11_start); else pass_cnt++;
      h = {8'($urandom_range(0, 255)), 8'($urandom)};
      t = {8'($urandom_range(0, 255)), 8'($urandom)};
      if (n == 0) begin h = 16'h3C00; t = 16'h1A05; end
      if (n == 1) begin h[15:8] = 8'd255; t[15:8] = 8'd0; end
      k = cyc;
      send_done(1'b1, h, t);
      wait_ready(r, 30);
      total_cnt++;
      if (r !== k + 10) $display("FAIL ready_latency%0d: got %0d want %0d", n, r, k + 10); else pass_cnt++;
      total_cnt++;
      if (bus.hum_bcd !== to_bcd(int'(h[15:8]))) $display("FAIL hum_bcd%0d: got %h want %h", n, bus.hum_bcd, to_bcd(int'(h[15:8]))); else pass_cnt++;
      total_cnt++;
      if (bus.tmp_bcd !== to_bcd(int'(t[15:8]))) $display("FAIL tmp_bcd%0d: got %h want %h", n, bus.tmp_bcd, to_bcd(int'(t[15:8]))); else pass_cnt++;
      total_cnt++;
      if (bus.stale !== 1'b0) $display("FAIL stale_clear%0d: got %b want 0", n, bus.stale); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.data_ready !== 1'b0) $display("FAIL ready_width%0d: got %b want 0", n, bus.data_ready); else pass_cnt++;
    end
  endtask

  task automatic test_fail();
    int s, s2, at, exp_s, t_exp, rc;
    logic [11:0] hb, tb;
    exp_s = tick_after(last_trig, PER) + 1;
    wait_start(s, 200);
    total_cnt++;
    if (s !== exp_s) $display("FAIL fail_start: got %0d want %0d", s, exp_s); else pass_cnt++;
    if (s < 0) s = exp_s;
    hb = bus.hum_bcd;
    tb = bus.tmp_bcd;
    rc = ready_cnt;
    @(negedge clk);
    send_done(1'b0, 16'($urandom), 16'($urandom));
    @(negedge clk);
    total_cnt++;
    if (bus.err_cnt !== 8'd1) $display("FAIL err_invalid: got %0d want 1", bus.err_cnt); else pass_cnt++;
    total_cnt++;
    if (bus.stale !== 1'b1 || bus.busy !== 1'b0) $display("FAIL stale_invalid: got stale=%b busy=%b want 1/0", bus.stale, bus.busy); else pass_cnt++;

    exp_s = tick_after(s, PER) + 1;
    wait_start(s2, 200);
    total_cnt++;
    if (s2 !== exp_s) $display("FAIL timeout_start: got %0d want %0d", s2, exp_s); else pass_cnt++;
    if (s2 < 0) s2 = exp_s;
    bus.auto_en = 1'b0;
    last_trig = s2;
    t_exp = tick_after(s2 + 1, TMO) + 1;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.err_cnt !== 8'd1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (at !== t_exp) $display("FAIL timeout_edge: got %0d want %0d", at, t_exp); else pass_cnt++;
    total_cnt++;
    if (bus.err_cnt !== 8'd2 || bus.stale !== 1'b1) $display("FAIL err_timeout: got err=%0d stale=%b want 2/1", bus.err_cnt, bus.stale); else pass_cnt++;

    repeat (3) @(negedge clk);
    send_done(1'b1, 16'hFF00, 16'hFF00);
    repeat (12) @(negedge clk);
    total_cnt++;
    if (ready_cnt !== rc) $display("FAIL no_ready_on_fail: got %0d pulses want %0d", ready_cnt, rc); else pass_cnt++;
    total_cnt++;
    if (bus.hum_bcd !== hb || bus.tmp_bcd !== tb) $display("FAIL bcd_held: got %h/%h want %h/%h", bus.hum_bcd, bus.tmp_bcd, hb, tb); else pass_cnt++;
  endtask

  task automatic test_req();
    int s, s2, s3, x, k, exp_s, r;
    @(negedge clk);
    k = cyc;
    pulse_req();
    exp_s = imax(k + 2, tick_after(last_trig, MING) + 1);
    wait_start(s, 200);
    total_cnt++;
    if (s !== exp_s) $display("FAIL req_start: got %0d want %0d", s, exp_s); else pass_cnt++;
    if (s < 0) s = exp_s;
    @(negedge clk);
    send_done(1'b1, {8'($urandom_range(0, 255)), 8'h00}, 16'h6300);
    wait_ready(r, 30);
    while (cyc < s + 20) @(negedge clk);
    k = cyc;
    pulse_req();
    exp_s = imax(k + 2, tick_after(s, MING) + 1);
    wait_start(s2, 200);
    total_cnt++;
    if (s2 !== exp_s) $display("FAIL req_early_held: got %0d want %0d", s2, exp_s); else pass_cnt++;
    if (s2 < 0) s2 = exp_s;
    repeat (2) @(negedge clk);
    pulse_req();
    send_done(1'b1, 16'h2A00, 16'h1500);
    exp_s = tick_after(s2, MING) + 1;
    wait_start(s3, 200);
    total_cnt++;
    if (s3 !== exp_s) $display("FAIL req_in_wait: got %0d want %0d", s3, exp_s); else pass_cnt++;
    if (s3 < 0) s3 = exp_s;
    @(negedge clk);
    send_done(1'b1, 16'h2B00, 16'h1600);
    wait_start(x, 200);
    total_cnt++;
    if (x !== -1) $display("FAIL req_single_extra: got start at %0d want none", x); else pass_cnt++;
    last_trig = s3;
  endtask

  task automatic test_reset_convert();
    int s, x, k, exp_s;
    logic [37:0] outs;
    k = cyc;
    pulse_req();
    exp_s = imax(k + 2, tick_after(last_trig, MING) + 1);
    wait_start(s, 200);
    total_cnt++;
    if (s !== exp_s) $display("FAIL rc_start: got %0d want %0d", s, exp_s); else pass_cnt++;
    @(negedge clk);
    send_done(1'b1, 16'h6300, 16'h0100);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.err_cnt === 8'd0) $display("FAIL rc_precond: got busy=%b err=%0d want 1/nonzero", bus.busy, bus.err_cnt); else pass_cnt++;
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    #1 rst = 1'b1;
    #1;
    outs = {bus.dht11_start, bus.hum_bcd, bus.tmp_bcd, bus.data_ready, bus.stale, bus.err_cnt, bus.busy};
    total_cnt++;
    if (outs !== 38'd0) $display("FAIL async_reset: got %h want 0", outs); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    wait_start(x, 120);
    total_cnt++;
    if (x !== -1) $display("FAIL pending_reset: got start at %0d want none", x); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_req();
    wait_start(s, 200);
    exp_s = tick_after(0, MING) + 1;
    total_cnt++;
    if (s !== exp_s) $display("FAIL gap_after_reset: got %0d want %0d", s, exp_s); else pass_cnt++;
    @(negedge clk);
    send_done(1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_err_saturate();
    int s;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pulse_req();
      wait_start(s, 100);
      if (s < 0) begin
        total_cnt++;
        $display("FAIL sat_start%0d: got no start want one within 100 cycles", i);
        break;
      end
      @(negedge clk);
      send_done(1'b0, 16'($urandom), 16'($urandom));
      if (i == 0) begin
        total_cnt++;
        if (bus.err_cnt !== 8'd1) $display("FAIL sat_first: got %0d want 1", bus.err_cnt); else pass_cnt++;
      end
      if (i == 254) begin
        total_cnt++;
        if (bus.err_cnt !== 8'd255) $display("FAIL sat_reach: got %0d want 255", bus.err_cnt); else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (bus.err_cnt !== 8'd255 || bus.stale !== 1'b1) $display("FAIL sat_hold: got err=%0d stale=%b want 255/1", bus.err_cnt, bus.stale); else pass_cnt++;
  endtask

  initial begin
    bus.req         = 1'b0;
    bus.auto_en     = 1'b0;
    bus.humidity    = 16'h0;
    bus.temperature = 16'h0;
    bus.dht11_done  = 1'b0;
    bus.dht11_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_auto_period();
    test_fail();
    test_req();
    test_reset_convert();
    test_err_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
